// File: rtl/hazard_unit_mc_pkg.sv
// Shared definitions for the hazard/forwarding controller: forwarding mux
// select codes and the MUL/DIV scoreboard state encoding.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Counter width able to hold the larger of the two latencies.
    function automatic int md_cnt_w(input int mul_lat, input int div_lat);
        int lat;
        lat = (div_lat > mul_lat) ? div_lat : mul_lat;
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Bundle of datapath-side pipeline information and the controls the hazard
// unit returns; master is the datapath, slave is the hazard unit.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] Rs_D, Rt_D, Rs_E, Rt_E;
    logic [REG_AW-1:0] writeReg_E, writeReg_M, writeReg_W;
    logic              reg_write_E, reg_write_M, reg_write_W;
    logic              memtoReg_E, memtoReg_M;
    logic              branch_D, jump_D, branch_taken_D;
    logic              md_op_D, hilo_read_D, md_start_E, md_is_div_E;
    logic              mem_req_M, mem_ready_M;

    logic              stall_F, stall_D, stall_E, stall_M;
    logic              flush_D, flush_E, flush_W;
    logic              forwardA_D, forwardB_D;
    logic [1:0]        forwardA_E, forwardB_E;
    logic              md_busy, md_done, md_overlap_err;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output Rs_D, Rt_D, Rs_E, Rt_E, writeReg_E, writeReg_M, writeReg_W,
               reg_write_E, reg_write_M, reg_write_W, memtoReg_E, memtoReg_M,
               branch_D, jump_D, branch_taken_D, md_op_D, hilo_read_D,
               md_start_E, md_is_div_E, mem_req_M, mem_ready_M,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
               forwardA_D, forwardB_D, forwardA_E, forwardB_E,
               md_busy, md_done, md_overlap_err, stall_count
    );

    modport slave (
        input  Rs_D, Rt_D, Rs_E, Rt_E, writeReg_E, writeReg_M, writeReg_W,
               reg_write_E, reg_write_M, reg_write_W, memtoReg_E, memtoReg_M,
               branch_D, jump_D, branch_taken_D, md_op_D, hilo_read_D,
               md_start_E, md_is_div_E, mem_req_M, mem_ready_M,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
               forwardA_D, forwardB_D, forwardA_E, forwardB_E,
               md_busy, md_done, md_overlap_err, stall_count
    );

endinterface

// File: rtl/hazard_unit_mc_md_scoreboard.sv
// Multi-cycle MUL/DIV occupancy tracker: IDLE/BUSY/DONE FSM with a latency
// counter, a one-cycle HI/LO write strobe and a sticky overlap error.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_is_div,
    input  logic i_stall_e,
    output logic o_busy,
    output logic o_done,
    output logic o_overlap_err
);

    localparam int CW = md_cnt_w(MUL_LAT, DIV_LAT);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);

    md_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_accept;
    logic [CW-1:0] w_load;

    // Issue only when the instruction actually leaves Execute.
    assign w_accept = i_start && !i_stall_e;
    assign w_load   = i_is_div ? DIV_LOAD : MUL_LOAD;

    // r_cnt holds the BUSY cycles still to run; the unit keeps counting
    // through pipeline freezes because it is not clocked by the pipeline.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                MD_BUSY: begin
                    if (i_start) begin
                        r_err <= 1'b1;
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= CW'(1)) begin
                        r_state <= MD_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_cnt  <= w_load;
                        r_busy <= 1'b1;
                        if (w_load == '0) begin
                            r_state <= MD_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= MD_BUSY;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_overlap_err = r_err;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: RAW
// forwarding, load-use/branch/MUL-DIV stalls, memory wait freezing, stall counter.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 16
) (
    input logic           clk,
    input logic           rst_n,
    hazard_unit_mc_if.slave hz
);

    logic             w_lw_stall;
    logic             w_br_stall;
    logic             w_md_stall;
    logic             w_mem_stall;
    logic             w_hz;
    logic             w_stall_fd;
    logic             w_md_busy;
    logic             w_md_done;
    logic             w_md_err;
    logic [CNT_W-1:0] r_stall_cnt;

    // M has the younger result, so it wins over W.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] wr_m,
        input logic              we_m,
        input logic [REG_AW-1:0] wr_w,
        input logic              we_w
    );
        if (src != '0 && src == wr_m && we_m) begin
            return FWD_M;
        end else if (src != '0 && src == wr_w && we_w) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    function automatic logic src_hit(
        input logic [REG_AW-1:0] wr,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt
    );
        return (wr != '0) && (wr == rs || wr == rt);
    endfunction

    always_comb begin
        w_lw_stall  = hz.memtoReg_E && src_hit(hz.writeReg_E, hz.Rs_D, hz.Rt_D);
        w_br_stall  = hz.branch_D &&
                      ((hz.reg_write_E && src_hit(hz.writeReg_E, hz.Rs_D, hz.Rt_D)) ||
                       (hz.memtoReg_M  && src_hit(hz.writeReg_M, hz.Rs_D, hz.Rt_D)));
        // mfhi/mflo may proceed in the DONE cycle: HI/LO is written that edge.
        w_md_stall  = w_md_busy && !w_md_done && (hz.md_op_D || hz.hilo_read_D);
        w_mem_stall = hz.mem_req_M && !hz.mem_ready_M;
        w_hz        = w_lw_stall || w_br_stall || w_md_stall;
        w_stall_fd  = w_hz || w_mem_stall;
    end

    assign hz.stall_F = w_stall_fd;
    assign hz.stall_D = w_stall_fd;
    assign hz.stall_E = w_mem_stall;
    assign hz.stall_M = w_mem_stall;
    assign hz.flush_W = w_mem_stall;
    // A frozen pipeline must not lose the bubble or the fetched slot.
    assign hz.flush_E = (w_hz || hz.jump_D) && !w_mem_stall;
    assign hz.flush_D = (hz.jump_D || hz.branch_taken_D) && !w_stall_fd;

    assign hz.forwardA_E = fwd_sel(hz.Rs_E, hz.writeReg_M, hz.reg_write_M,
                                   hz.writeReg_W, hz.reg_write_W);
    assign hz.forwardB_E = fwd_sel(hz.Rt_E, hz.writeReg_M, hz.reg_write_M,
                                   hz.writeReg_W, hz.reg_write_W);
    assign hz.forwardA_D = (hz.Rs_D != '0) && (hz.Rs_D == hz.writeReg_M) && hz.reg_write_M;
    assign hz.forwardB_D = (hz.Rt_D != '0) && (hz.Rt_D == hz.writeReg_M) && hz.reg_write_M;

    md_scoreboard #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_sb (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (hz.md_start_E),
        .i_is_div      (hz.md_is_div_E),
        .i_stall_e     (w_mem_stall),
        .o_busy        (w_md_busy),
        .o_done        (w_md_done),
        .o_overlap_err (w_md_err)
    );

    assign hz.md_busy        = w_md_busy;
    assign hz.md_done        = w_md_done;
    assign hz.md_overlap_err = w_md_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_fd && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign hz.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: inline scenario checks plus a
// queue of expected md_done cycles consumed by a done monitor.
module tb_hazard_unit_mc;

    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   exp_cnt;
    bit   exp_stall;
    int   done_q[$];

    hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

    hazard_unit_mc #(
        .REG_AW (REG_AW),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Expected stall counter, driven by each scenario's own stall expectation.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_cnt <= 0;
        else if (exp_stall && exp_cnt != CNT_MAX) exp_cnt <= exp_cnt + 1;
    end

    always @(negedge clk) begin
        if (hz.md_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL md_done_unexpected: md_done=1 at cycle %0d, none expected", cyc);
            end else begin
                int exp_c;
                exp_c = done_q.pop_front();
                if (cyc !== exp_c) begin
                    errors++;
                    $display("FAIL md_done_cycle: got cycle %0d want %0d", cyc, exp_c);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    task automatic drive_idle();
        hz.Rs_D = '0; hz.Rt_D = '0; hz.Rs_E = '0; hz.Rt_E = '0;
        hz.writeReg_E = '0; hz.writeReg_M = '0; hz.writeReg_W = '0;
        hz.reg_write_E = 0; hz.reg_write_M = 0; hz.reg_write_W = 0;
        hz.memtoReg_E = 0; hz.memtoReg_M = 0;
        hz.branch_D = 0; hz.jump_D = 0; hz.branch_taken_D = 0;
        hz.md_op_D = 0; hz.hilo_read_D = 0; hz.md_start_E = 0; hz.md_is_div_E = 0;
        hz.mem_req_M = 0; hz.mem_ready_M = 1;
        exp_stall = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        tick();
        tick();
        checks++;
        if (hz.md_busy !== 1'b0 || hz.md_done !== 1'b0 || hz.md_overlap_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_md: got busy=%b done=%b err=%b want 0 0 0",
                     hz.md_busy, hz.md_done, hz.md_overlap_err);
        end
        checks++;
        if (hz.stall_count !== 4'd0 || hz.stall_F !== 1'b0 || hz.forwardA_E !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: got cnt=%0d stall_F=%b fwdA=%b want 0 0 00",
                     hz.stall_count, hz.stall_F, hz.forwardA_E);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        hz.Rs_E = 5'd3; hz.Rs_D = 5'd3;
        hz.writeReg_M = 5'd3; hz.reg_write_M = 1;
        hz.writeReg_W = 5'd3; hz.reg_write_W = 1;
        @(negedge clk);
        checks++;
        if (hz.forwardA_E !== 2'b10 || hz.forwardA_D !== 1'b1) begin
            errors++;
            $display("FAIL fwd_m_priority: got fwdA_E=%b fwdA_D=%b want 10 1", hz.forwardA_E, hz.forwardA_D);
        end
        tick();
        hz.reg_write_M = 0;
        @(negedge clk);
        checks++;
        if (hz.forwardA_E !== 2'b01 || hz.forwardA_D !== 1'b0) begin
            errors++;
            $display("FAIL fwd_w: got fwdA_E=%b fwdA_D=%b want 01 0", hz.forwardA_E, hz.forwardA_D);
        end
        tick();
        hz.Rs_E = 5'd0; hz.writeReg_W = 5'd0;
        hz.Rt_E = 5'd5; hz.writeReg_M = 5'd5; hz.reg_write_M = 1;
        @(negedge clk);
        checks++;
        if (hz.forwardA_E !== 2'b00 || hz.forwardB_E !== 2'b10) begin
            errors++;
            $display("FAIL fwd_r0_and_b: got fwdA_E=%b fwdB_E=%b want 00 10", hz.forwardA_E, hz.forwardB_E);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_lw_stall();
        hz.memtoReg_E = 1; hz.writeReg_E = 5'd8; hz.Rt_D = 5'd8;
        exp_stall = 1;
        @(negedge clk);
        checks++;
        if (hz.stall_F !== 1'b1 || hz.stall_D !== 1'b1 || hz.flush_E !== 1'b1 || hz.stall_E !== 1'b0) begin
            errors++;
            $display("FAIL lw_stall: got F=%b D=%b flushE=%b E=%b want 1 1 1 0",
                     hz.stall_F, hz.stall_D, hz.flush_E, hz.stall_E);
        end
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (hz.stall_count !== 4'd1) begin
            errors++;
            $display("FAIL lw_stall_count: got %0d want 1", hz.stall_count);
        end
        tick();
        hz.memtoReg_E = 1; hz.writeReg_E = 5'd0; hz.Rs_D = 5'd0;
        @(negedge clk);
        checks++;
        if (hz.stall_F !== 1'b0) begin
            errors++;
            $display("FAIL lw_r0_nostall: got stall_F=%b want 0", hz.stall_F);
        end
        tick();
        drive_idle();
        hz.branch_D = 1; hz.branch_taken_D = 1;
        hz.reg_write_E = 1; hz.writeReg_E = 5'd9; hz.Rs_D = 5'd9;
        exp_stall = 1;
        @(negedge clk);
        checks++;
        if (hz.stall_D !== 1'b1 || hz.flush_D !== 1'b0 || hz.flush_E !== 1'b1) begin
            errors++;
            $display("FAIL br_stall: got stall_D=%b flush_D=%b flush_E=%b want 1 0 1",
                     hz.stall_D, hz.flush_D, hz.flush_E);
        end
        tick();
        drive_idle();
        hz.branch_D = 1; hz.memtoReg_M = 1; hz.writeReg_M = 5'd4; hz.Rt_D = 5'd4;
        exp_stall = 1;
        @(negedge clk);
        checks++;
        if (hz.stall_F !== 1'b1) begin
            errors++;
            $display("FAIL br_load_m_stall: got stall_F=%b want 1", hz.stall_F);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_mul();
        hz.md_start_E = 1; hz.md_is_div_E = 0;
        done_q.push_back(cyc + MUL_LAT - 1);
        @(negedge clk);
        checks++;
        if (hz.md_busy !== 1'b0 || hz.stall_F !== 1'b0) begin
            errors++;
            $display("FAIL mul_issue: got busy=%b stall_F=%b want 0 0", hz.md_busy, hz.stall_F);
        end
        tick();
        hz.md_start_E = 0; hz.hilo_read_D = 1;
        for (int i = 0; i < 2; i++) begin
            exp_stall = 1;
            @(negedge clk);
            checks++;
            if (hz.stall_F !== 1'b1 || hz.md_busy !== 1'b1 || hz.md_done !== 1'b0) begin
                errors++;
                $display("FAIL mul_stall%0d: got stall_F=%b busy=%b done=%b want 1 1 0",
                         i, hz.stall_F, hz.md_busy, hz.md_done);
            end
            tick();
        end
        exp_stall = 0;
        @(negedge clk);
        checks++;
        if (hz.md_done !== 1'b1 || hz.stall_F !== 1'b0) begin
            errors++;
            $display("FAIL mul_release: got done=%b stall_F=%b want 1 0", hz.md_done, hz.stall_F);
        end
        tick();
        drive_idle();
        checks++;
        if (hz.md_busy !== 1'b0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL mul_idle: got busy=%b pending=%0d want 0 0", hz.md_busy, done_q.size());
        end
    endtask

    task automatic test_div_memwait();
        hz.md_start_E = 1; hz.md_is_div_E = 1;
        done_q.push_back(cyc + DIV_LAT - 1);
        tick();
        drive_idle();
        tick();
        tick();
        tick();
        hz.mem_req_M = 1; hz.mem_ready_M = 0;
        for (int i = 0; i < 5; i++) begin
            exp_stall = 1;
            @(negedge clk);
            checks++;
            if (hz.stall_E !== 1'b1 || hz.stall_M !== 1'b1 || hz.flush_W !== 1'b1 ||
                hz.stall_F !== 1'b1 || hz.flush_E !== 1'b0) begin
                errors++;
                $display("FAIL memwait%0d: got E=%b M=%b fW=%b F=%b fE=%b want 1 1 1 1 0",
                         i, hz.stall_E, hz.stall_M, hz.flush_W, hz.stall_F, hz.flush_E);
            end
            tick();
        end
        drive_idle();
        for (int i = 0; i < 60 && done_q.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL div_timeout: got %0d pending md_done want 0", done_q.size());
            done_q.delete();
        end
        checks++;
        if (hz.md_busy !== 1'b0) begin
            errors++;
            $display("FAIL div_idle: got busy=%b want 0", hz.md_busy);
        end
    endtask

    task automatic test_overlap_reset();
        hz.md_start_E = 1; hz.md_is_div_E = 1;
        tick();
        hz.md_is_div_E = 0;
        @(negedge clk);
        checks++;
        if (hz.md_overlap_err !== 1'b0 || hz.md_busy !== 1'b1) begin
            errors++;
            $display("FAIL overlap_pre: got err=%b busy=%b want 0 1", hz.md_overlap_err, hz.md_busy);
        end
        tick();
        drive_idle();
        tick();
        tick();
        tick();
        checks++;
        if (hz.md_overlap_err !== 1'b1 || hz.md_busy !== 1'b1 || hz.stall_count !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL overlap_sticky: got err=%b busy=%b cnt=%0d want 1 1 %0d",
                     hz.md_overlap_err, hz.md_busy, hz.stall_count, exp_cnt);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (hz.md_busy !== 1'b0 || hz.md_overlap_err !== 1'b0 || hz.stall_count !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b err=%b cnt=%0d want 0 0 0",
                     hz.md_busy, hz.md_overlap_err, hz.stall_count);
        end
        tick();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        checks++;
        if (hz.md_busy !== 1'b0 || hz.md_overlap_err !== 1'b0) begin
            errors++;
            $display("FAIL post_abort: got busy=%b err=%b want 0 0", hz.md_busy, hz.md_overlap_err);
        end
    endtask

    task automatic test_combo_sat();
        hz.memtoReg_E = 1; hz.writeReg_E = 5'd8; hz.Rt_D = 5'd8;
        hz.jump_D = 1; hz.mem_req_M = 1; hz.mem_ready_M = 0;
        exp_stall = 1;
        @(negedge clk);
        checks++;
        if (hz.flush_E !== 1'b0 || hz.flush_D !== 1'b0 || hz.stall_F !== 1'b1 ||
            hz.stall_E !== 1'b1 || hz.flush_W !== 1'b1) begin
            errors++;
            $display("FAIL combo_flush: got fE=%b fD=%b F=%b E=%b fW=%b want 0 0 1 1 1",
                     hz.flush_E, hz.flush_D, hz.stall_F, hz.stall_E, hz.flush_W);
        end
        repeat (20) tick();
        checks++;
        if (hz.stall_count !== 4'hF || exp_cnt != CNT_MAX) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d want %0d", hz.stall_count, CNT_MAX);
        end
        tick();
        checks++;
        if (hz.stall_count !== 4'hF) begin
            errors++;
            $display("FAIL cnt_hold_max: got %0d want 15", hz.stall_count);
        end
        drive_idle();
        hz.jump_D = 1;
        @(negedge clk);
        checks++;
        if (hz.flush_D !== 1'b1 || hz.flush_E !== 1'b1 || hz.stall_F !== 1'b0) begin
            errors++;
            $display("FAIL jump_flush: got fD=%b fE=%b F=%b want 1 1 0", hz.flush_D, hz.flush_E, hz.stall_F);
        end
        tick();
        drive_idle();
        tick();
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        test_reset();
        test_forward();
        test_lw_stall();
        test_mul();
        test_div_memwait();
        test_overlap_reset();
        test_combo_sat();
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL done_queue_empty: got %0d pending want 0", done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
